aes_block_assembler: RTL and testbench

- Upstream feeder for the AES encipher round block.
- Packs a serial byte stream (from the RS-232 receiver) into 128-bit blocks and launches the cipher with a one-cycle `next` pulse.
- Captures the cipher result when `ready` returns and presents it on a valid/ready output port for the downstream serializer.
- Double-buffered: the next block's bytes are accepted while the current block is being enciphered.

---
 rtl/aes_stream_pkg.sv | 20 ++
 rtl/aes_block_assembler_if.sv | 29 ++
 rtl/aes_byte_packer.sv | 68 ++++++
 rtl/aes_block_assembler.sv | 80 ++++++++
 tb/tb_aes_block_assembler.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES byte-stream front end.
// Holds the cipher FSM encoding, block geometry and byte-lane mapping.
package aes_stream_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef logic [BLOCK_W-1:0] block_t;

  localparam logic [1:0] C_IDLE      = 2'd0;
  localparam logic [1:0] C_START     = 2'd1;
  localparam logic [1:0] C_WAIT_LOW  = 2'd2;
  localparam logic [1:0] C_WAIT_HIGH = 2'd3;

  // Byte k of a block occupies bits [127-8k -: 8]; this returns the lane's LSB.
  function automatic logic [6:0] lane_lsb(input logic [3:0] idx);
    return 7'd120 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/aes_block_assembler_if.sv
// Byte-in, cipher-side and block-out signals of the assembler.
// slave is the assembler's view; master is the surrounding system's view.
interface aes_block_assembler_if;
  import aes_stream_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       core_next;
  block_t     core_block;
  logic       core_ready;
  block_t     core_result;
  block_t     out_block;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;

  modport slave (
    input  in_data, in_valid, core_ready, core_result, out_ready,
    output in_ready, core_next, core_block, out_block, out_valid, busy, frame_err
  );

  modport master (
    output in_data, in_valid, core_ready, core_result, out_ready,
    input  in_ready, core_next, core_block, out_block, out_valid, busy, frame_err
  );

endinterface

// File: rtl/aes_byte_packer.sv
// Packs accepted bytes MSB-first into a 128-bit buffer and flags a full block.
// A partial block that sits idle for TIMEOUT_CYCLES is dropped with a frame_err pulse.
module aes_byte_packer
  import aes_stream_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_clear,
  output logic       o_ready,
  output block_t     o_buf,
  output logic       o_buf_full,
  output logic       o_frame_err
);

  block_t      r_buf;
  logic [3:0]  r_byte_cnt;
  logic        r_buf_full;
  logic [23:0] r_timer;
  logic        r_frame_err;

  logic w_accept;
  logic w_timeout;

  assign w_accept  = i_valid && !r_buf_full;
  // An arriving byte always beats the timeout on the same edge.
  assign w_timeout = (TIMEOUT_CYCLES != 24'd0) && (r_byte_cnt != 4'd0) && !r_buf_full &&
                     !w_accept && (r_timer == TIMEOUT_CYCLES - 24'd1);

  // NOTE: data-only register without reset; every lane is rewritten before
  // buf_full can rise, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[lane_lsb(r_byte_cnt) +: 8] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt  <= '0;
      r_buf_full  <= 1'b0;
      r_timer     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;

      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
        if (r_byte_cnt == 4'(BLOCK_BYTES - 1)) r_buf_full <= 1'b1;
      end else if (w_timeout) begin
        r_byte_cnt <= '0;
      end

      if (i_clear) r_buf_full <= 1'b0;

      if (w_accept || w_timeout || r_byte_cnt == 4'd0 || r_buf_full) r_timer <= '0;
      else                                                           r_timer <= r_timer + 24'd1;
    end
  end

  assign o_ready     = !r_buf_full;
  assign o_buf       = r_buf;
  assign o_buf_full  = r_buf_full;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/aes_block_assembler.sv
// Feeds 128-bit blocks from a byte stream into the AES core and holds each
// result on a valid/ready port; the next block fills while the current one runs.
module aes_block_assembler
  import aes_stream_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  aes_block_assembler_if.slave  bus
);

  logic [1:0] r_state;
  block_t     r_core_block;
  block_t     r_out_block;
  logic       r_out_valid;

  block_t     w_buf;
  logic       w_buf_full;
  logic       w_in_ready;
  logic       w_frame_err;
  logic       w_launch;

  // Launch waits for an empty output slot so a capture never clobbers unread data.
  assign w_launch = w_buf_full && (r_state == C_IDLE) && !r_out_valid;

  aes_byte_packer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data      (bus.in_data),
    .i_valid     (bus.in_valid),
    .i_clear     (w_launch),
    .o_ready     (w_in_ready),
    .o_buf       (w_buf),
    .o_buf_full  (w_buf_full),
    .o_frame_err (w_frame_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= C_IDLE;
      r_core_block <= '0;
      r_out_block  <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      case (r_state)
        C_IDLE: begin
          if (w_launch) begin
            r_core_block <= w_buf;
            r_state      <= C_START;
          end
        end
        C_START:    r_state <= C_WAIT_LOW;
        // A core that never drops ready leaves the FSM parked here on purpose.
        C_WAIT_LOW: if (!bus.core_ready) r_state <= C_WAIT_HIGH;
        C_WAIT_HIGH: begin
          if (bus.core_ready) begin
            r_out_block <= bus.core_result;
            r_out_valid <= 1'b1;
            r_state     <= C_IDLE;
          end
        end
        default:    r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.core_next  = (r_state == C_START);
  assign bus.core_block = r_core_block;
  assign bus.out_block  = r_out_block;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = (r_state != C_IDLE);
  assign bus.frame_err  = w_frame_err;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Bench for aes_block_assembler: cipher stand-in plus a transaction-level model
// of byte packing, timeout, launch and output ordering, with directed and random traffic.
module tb_aes_block_assembler;
  import aes_stream_pkg::*;

  localparam logic [23:0] TO   = 24'd20;
  localparam block_t      ONES = '1;

  logic clk = 1'b0;
  logic reset_n;

  aes_block_assembler_if bus();

  aes_block_assembler #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input block_t got, input block_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  block_t acc_blk;
  int     acc_n;
  int     idle_cnt;
  bit     exp_ferr;
  block_t plain_q[$];
  block_t ct_q[$];
  int     c_state;
  int     c_cnt;
  block_t c_blk;
  bit     rise_pending, inflight, prev_next, prev_ov, prev_hs;
  block_t prev_ob, last_cb;
  int     next_cnt = 0;
  int     out_cnt  = 0;
  bit     rnd_out_ready = 1'b0;

  task automatic model_clear();
    acc_blk = '0; acc_n = 0; idle_cnt = 0; exp_ferr = 1'b0;
    plain_q.delete(); ct_q.delete();
    c_state = 0; c_cnt = 0; c_blk = '0;
    rise_pending = 1'b0; inflight = 1'b0; prev_next = 1'b0;
    prev_ov = 1'b0; prev_hs = 1'b0; prev_ob = '0; last_cb = '0;
  endtask

  // Cipher stand-in and protocol monitor, evaluated on the falling edge.
  initial begin
    block_t exp_pt;
    bus.core_ready  = 1'b1;
    bus.core_result = '0;
    model_clear();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_clear();
        bus.core_ready = 1'b1;
      end else begin
        check("frame_err", bus.frame_err, exp_ferr);
        exp_ferr = 1'b0;

        if (rise_pending) begin
          check("out_valid_rise", bus.out_valid, 1);
          check("out_block_capture", bus.out_block, bus.core_result);
          rise_pending = 1'b0;
          inflight     = 1'b0;
        end

        if (c_state == 1) begin
          bus.core_ready = 1'b0;
          c_cnt   = 50;
          c_state = 2;
        end else if (c_state == 2) begin
          c_cnt--;
          if (c_cnt == 0) begin
            bus.core_ready  = 1'b1;
            bus.core_result = c_blk ^ ONES;
            rise_pending    = 1'b1;
            c_state         = 0;
          end
        end

        if (bus.core_next) begin
          next_cnt++;
          check("next_single_cycle", prev_next, 0);
          check("cipher_idle_at_next", c_state, 0);
          check("launch_has_block", plain_q.size(), 1);
          if (plain_q.size() > 0) begin
            exp_pt = plain_q.pop_front();
            check("core_block", bus.core_block, exp_pt);
            ct_q.push_back(exp_pt ^ ONES);
          end
          c_blk    = bus.core_block;
          last_cb  = bus.core_block;
          c_state  = 1;
          inflight = 1'b1;
        end else begin
          check("core_block_hold", bus.core_block, last_cb);
        end
        prev_next = bus.core_next;

        check("busy", bus.busy, inflight);

        if (prev_ov && !prev_hs) begin
          check("out_valid_hold", bus.out_valid, 1);
          check("out_block_hold", bus.out_block, prev_ob);
        end
        if (prev_hs) check("out_valid_clear", bus.out_valid, 0);
        if (bus.out_valid && bus.out_ready) begin
          out_cnt++;
          if (ct_q.size() == 0) check("out_unexpected", bus.out_valid, 0);
          else                  check("out_block", bus.out_block, ct_q.pop_front());
        end
        prev_ov = bus.out_valid;
        prev_ob = bus.out_block;
        prev_hs = bus.out_valid && bus.out_ready;

        check("in_ready", bus.in_ready, plain_q.size() == 0);

        if (bus.in_valid && bus.in_ready) begin
          acc_blk  = {acc_blk[BLOCK_W-9:0], bus.in_data};
          acc_n++;
          idle_cnt = 0;
          if (acc_n == BLOCK_BYTES) begin
            plain_q.push_back(acc_blk);
            acc_n = 0;
          end
        end else if (acc_n > 0) begin
          idle_cnt++;
          if (idle_cnt == int'(TO)) begin
            acc_n    = 0;
            idle_cnt = 0;
            exp_ferr = 1'b1;
          end
        end else begin
          idle_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit acc;
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 400 && !done; i++) begin
      if (rnd_out_ready) bus.out_ready = 1'($urandom_range(0, 1));
      acc = bus.in_ready;
      tick();
      if (acc) done = 1'b1;
      else     waits++;
    end
    check("byte_accepted", done, 1);
  endtask

  task automatic wait_next(input string tag, input int budget);
    int n = 0;
    while (!bus.core_next && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.core_next, 1);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.out_valid, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((bus.busy || bus.out_valid || !bus.in_ready) && n < 400) begin
      tick();
      n++;
    end
    check(tag, {bus.busy, bus.out_valid, !bus.in_ready}, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     w;
    int     nb;
    int     ob;
    int     n;
    int     gap;
    block_t blk;
    logic [7:0] d;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   bus.in_ready, 1);
    check("rst_core_next",  bus.core_next, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_out_valid",  bus.out_valid, 0);
    check("rst_frame_err",  bus.frame_err, 0);
    check("rst_core_block", bus.core_block, '0);
    check("rst_out_block",  bus.out_block, '0);
    reset_n = 1'b1;
    tick();

    // Scenario 1: 00,11,...,FF
    nb = next_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), w);
    bus.in_valid = 1'b0;
    wait_next("s1_next", 10);
    check("s1_core_block", bus.core_block, 128'h00112233445566778899AABBCCDDEEFF);
    wait_out_valid("s1_out_valid", 100);
    check("s1_out_block", bus.out_block, 128'hFFEEDDCCBBAA99887766554433221100);
    check("s1_single_next", next_cnt - nb, 1);
    bus.out_ready = 1'b1;
    tick();
    check("s1_consumed", bus.out_valid, 0);

    // Scenario 2: 32 bytes back-to-back, downstream always ready
    nb = next_cnt;
    ob = out_cnt;
    for (int i = 0; i < 32; i++) begin
      send_byte(8'($urandom), w);
      if (i == 16) check("s2_in_ready_low_cycles", w, 1);
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (out_cnt - ob < 2 && n < 400) begin
      tick();
      n++;
    end
    check("s2_outputs", out_cnt - ob, 2);
    check("s2_nexts", next_cnt - nb, 2);

    // Scenario 3: result held, second block waits in the buffer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), w);
    bus.in_valid = 1'b0;
    wait_out_valid("s3_out_valid", 100);
    blk = '0;
    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom);
      blk = {blk[BLOCK_W-9:0], d};
      send_byte(d, w);
    end
    bus.in_valid = 1'b0;
    nb = next_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s3_in_ready_low", bus.in_ready, 0);
    end
    check("s3_no_next", next_cnt - nb, 0);
    bus.out_ready = 1'b1;
    tick();
    check("s3_consumed", bus.out_valid, 0);
    check("s3_next_not_yet", bus.core_next, 0);
    tick();
    check("s3_next_fires", bus.core_next, 1);
    check("s3_core_block", bus.core_block, blk);
    wait_drain("s3_drain");

    // Scenario 4: partial block timeout, byte beating the timeout, clean restart
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), w);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("s4_ferr_at_%0d", k), bus.frame_err, k == 20);
    end
    tick();
    check("s4_ferr_one_cycle", bus.frame_err, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), w);
    bus.in_valid = 1'b0;
    repeat (19) tick();
    send_byte(8'h5A, w);
    bus.in_valid = 1'b0;
    check("s4_byte_wins", bus.frame_err, 0);
    tick();
    check("s4_byte_wins_next", bus.frame_err, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), w);
    bus.in_valid = 1'b0;
    wait_next("s4_merged_next", 10);
    wait_drain("s4_merged_drain");
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), w);
    bus.in_valid = 1'b0;
    wait_next("s4_next", 10);
    check("s4_core_block", bus.core_block, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    wait_drain("s4_drain");

    // Scenario 5: asynchronous reset while waiting for the cipher result
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), w);
    bus.in_valid = 1'b0;
    wait_next("s5_next", 10);
    repeat (10) tick();
    check("s5_busy_before", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("s5_async_busy",       bus.busy, 0);
    check("s5_async_in_ready",   bus.in_ready, 1);
    check("s5_async_out_valid",  bus.out_valid, 0);
    check("s5_async_core_next",  bus.core_next, 0);
    check("s5_async_core_block", bus.core_block, '0);
    check("s5_async_out_block",  bus.out_block, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    check("s5_post_in_ready",  bus.in_ready, 1);
    check("s5_post_busy",      bus.busy, 0);
    check("s5_post_out_valid", bus.out_valid, 0);

    // Random traffic: gaps (some past the timeout) and random downstream backpressure
    rnd_out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 25)) : int'($urandom_range(0, 2));
      bus.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      send_byte(8'($urandom), w);
    end
    rnd_out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("final_drain");
    repeat (30) tick();
    check("final_ct_empty",    ct_q.size(), 0);
    check("final_plain_empty", plain_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
